instr_encoder: RTL
==================

Name: instr_encoder

Overview:
Packs symbolic instruction requests into the nic8 instruction byte format and writes the result into program RAM. The format is {cond[1], cond[0], source[1:0], dest[2:0], indexed}. An immediate operand byte follows the opcode when indexed=0. The block sits between the host/boot path and program memory, and produces exactly the byte stream the CPU control decoder consumes. Requests are buffered in a small FIFO, and an emitter FSM streams one byte per cycle into RAM.

Parameters:
ADDR_W, 8, program RAM address width
DEPTH, 4, request FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
load  in  1  one-cycle pulse: set write pointer to load_addr
load_addr  in  ADDR_W  new write address
req_valid  in  1  request present
req_ready  out  1  FIFO can accept (not full)
req_cond  in  2  {jumpIfCarry/bit7, jumpIfZero-subtract/bit6}
req_source  in  2  0=M 1=E 2=A 3=X
req_dest  in  3  0..6 valid; 7 illegal
req_indexed  in  1  1=indexed, 0=immediate byte follows
req_imm  in  8  immediate operand (ignored if indexed)
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  RAM address
wr_data  out  8  RAM data
busy  out  1  FIFO non-empty or FSM not IDLE
err  out  1  sticky: illegal dest request was dropped
wrapped  out  1  sticky: write address wrapped past max

Behaviour:
- Clock/reset: one clock, clk. reset_n is asynchronous and active-low. While reset_n=0: FIFO empty, FSM=IDLE, write pointer=0, wr_en=0, wr_addr=0, wr_data=0, err=0, wrapped=0, req_ready=1.
- Accept: a request is taken on a rising edge when req_valid & req_ready.
  - Dest 7: the request is accepted but not enqueued. err sets next cycle.
  - Otherwise push {imm, ir, has_imm=~indexed}, with ir = {cond, source, dest, indexed}.
  - Pop and push in the same cycle is allowed when full. req_ready stays combinational on the registered count only (count<DEPTH), so it is 0 when full even if a pop is pending.
- FSM, outputs registered:
  - IDLE: if FIFO non-empty, pop the head into a holding register and go to OPCODE.
  - OPCODE: wr_en=1, wr_data=ir, wr_addr=ptr; ptr++. If has_imm go to IMM. Else, if FIFO non-empty, pop the next entry and stay in OPCODE (back-to-back); otherwise go to IDLE.
  - IMM: wr_en=1, wr_data=imm, wr_addr=ptr; ptr++. Then pop the next entry into OPCODE if available, else go to IDLE.
- Latency:
  - Request accepted at edge N: opcode write is visible at edge N+2 (pop at N+1).
  - Sustained rate is 1 byte/cycle, so an indexed stream runs at 1 request/cycle.
- Address: the pointer increments modulo 2^ADDR_W. On the increment from all-ones to 0, wrapped sets; writing continues.
- Load:
  - Honoured only when busy=0. Pointer becomes load_addr on the next edge.
  - load while busy=1 is ignored; err is not set.
  - load coincident with a request accept while idle is legal: the pointer loads first, and the request writes at load_addr.
- wr_en is high for exactly one cycle per byte. wr_data and wr_addr hold their last value when wr_en=0.
- Reset mid-stream: in-flight bytes are lost. No partial opcode/imm recovery.

Decomposition:
- Shared package nic8_pkg:
  - source codes SRC_M/E/A/X = 0..3
  - dest codes DST_IR/PC/A/X/B/MEM/Q = 0..6, DST_ILLEGAL=7
  - bit positions of the instruction byte
  - encode_ir function
  - FSM state enum IDLE/OPCODE/IMM
- The control decoder and this block both use the package, so the encoding lives in one place.
- One sub-module, instr_fifo: a synchronous FIFO parameterized by DEPTH and width 16 (8 imm + 7 ir fields + has_imm, with ir[0] = ~has_imm). It exposes full, empty and count.

Test Plan:
- Reset, then one request {cond=0, src=A(2), dest=X(3), indexed=1}. Expect a single write of 0x27 at addr 0 two edges later; busy falls after it.
- Request {cond=0, src=E(1), dest=A(2), indexed=0, imm=0x5A} after load_addr=0x10. Expect writes 0x14@0x10, then 0x5A@0x11 on consecutive cycles.
- Jump encoding {cond=3, src=E, dest=PC(1), indexed=0, imm=0x80}. Expect 0xD2 followed by 0x80.
- Burst of 6 indexed requests with DEPTH=4 and req_valid held high:
  - req_ready drops when the FIFO holds 4;
  - all 6 opcodes land at consecutive addresses with no gaps and no loss.
- Request with dest=7 between two legal ones. Expect only two writes, err=1 sticky, and the pointer advances by only 2.
- load_addr=0xFF with one immediate request. Expect opcode@0xFF and imm@0x00, and wrapped=1. A load pulse issued while busy leaves the pointer unchanged. Asserting reset_n=0 mid-burst clears all outputs immediately.

Source files
------------

// File: rtl/nic8_pkg.sv
// nic8 instruction byte format {cond[1], cond[0], source[1:0], dest[2:0], indexed}, shared with the control decoder.
// Holds the field codes, bit positions, the byte encoder and the emitter state type.
package nic8_pkg;

  localparam logic [1:0] SRC_M = 2'd0;
  localparam logic [1:0] SRC_E = 2'd1;
  localparam logic [1:0] SRC_A = 2'd2;
  localparam logic [1:0] SRC_X = 2'd3;

  localparam logic [2:0] DST_IR      = 3'd0;
  localparam logic [2:0] DST_PC      = 3'd1;
  localparam logic [2:0] DST_A       = 3'd2;
  localparam logic [2:0] DST_X       = 3'd3;
  localparam logic [2:0] DST_B       = 3'd4;
  localparam logic [2:0] DST_MEM     = 3'd5;
  localparam logic [2:0] DST_Q       = 3'd6;
  localparam logic [2:0] DST_ILLEGAL = 3'd7;

  localparam int IR_COND_HI = 7;
  localparam int IR_COND_LO = 6;
  localparam int IR_SRC_HI  = 5;
  localparam int IR_SRC_LO  = 4;
  localparam int IR_DST_HI  = 3;
  localparam int IR_DST_LO  = 1;
  localparam int IR_IDX     = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPCODE = 2'd1,
    IMM    = 2'd2
  } emitState_t;

  // irHi is ir[7:1]; ir[0] is recovered as ~hasImm.
  typedef struct packed {
    logic [7:0] imm;
    logic [6:0] irHi;
    logic       hasImm;
  } fifoEntry_t;

  function automatic logic [7:0] encode_ir(
    input logic [1:0] cond,
    input logic [1:0] source,
    input logic [2:0] dest,
    input logic       indexed
  );
    logic [7:0] ir;
    ir = '0;
    ir[IR_COND_HI:IR_COND_LO] = cond;
    ir[IR_SRC_HI:IR_SRC_LO]   = source;
    ir[IR_DST_HI:IR_DST_LO]   = dest;
    ir[IR_IDX]                = indexed;
    return ir;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Show-ahead synchronous request FIFO: head visible combinationally, push/pop take effect on the next edge.
// A push while full is only taken when a pop happens in the same cycle; a pop while empty is ignored.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       headData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes nic8 requests into opcode(+immediate) bytes written to program RAM; opcode lands 2 edges after accept, then 1 byte/cycle.
// req_ready is low while the request FIFO is full; illegal-dest requests are accepted and dropped.
module instr_encoder
  import nic8_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cond,
  input  logic [1:0]        req_source,
  input  logic [2:0]        req_dest,
  input  logic              req_indexed,
  input  logic [7:0]        req_imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              err,
  output logic              wrapped
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic             accept;
  logic             illegalDest;
  logic             pushReq;
  logic [7:0]       reqIr;
  fifoEntry_t       pushEntry;
  fifoEntry_t       headEntry;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [CNT_W-1:0] fifoCount;
  logic             pop;

  emitState_t       state;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]       holdIr;
  logic [7:0]       holdImm;
  logic             holdHasImm;
  logic             emitting;
  logic [7:0]       emitByte;

  assign req_ready   = (fifoCount < DEPTH_CNT);
  assign accept      = req_valid && req_ready;
  assign illegalDest = (req_dest == DST_ILLEGAL);
  assign pushReq     = accept && !illegalDest && !fifoFull;
  assign reqIr       = encode_ir(req_cond, req_source, req_dest, req_indexed);
  assign pushEntry   = '{imm: req_imm, irHi: reqIr[7:1], hasImm: ~reqIr[IR_IDX]};

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fifoEntry_t))
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (pushReq),
    .pushData (pushEntry),
    .pop      (pop),
    .headData (headEntry),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // The next entry is pulled in the same cycle the last byte of the current one goes out.
  always_comb begin
    pop = 1'b0;
    if (!fifoEmpty) begin
      case (state)
        IDLE:    pop = 1'b1;
        OPCODE:  pop = !holdHasImm;
        IMM:     pop = 1'b1;
        default: pop = 1'b0;
      endcase
    end
  end

  assign busy     = !fifoEmpty || (state != IDLE);
  assign emitting = (state == OPCODE) || (state == IMM);
  assign emitByte = (state == IMM) ? holdImm : holdIr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      holdIr     <= '0;
      holdImm    <= '0;
      holdHasImm <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      err        <= 1'b0;
      wrapped    <= 1'b0;
    end else begin
      wr_en <= 1'b0;

      if (accept && illegalDest) err <= 1'b1;

      // Loads only land while fully idle, so they never race a pointer increment.
      if (load && !busy) ptr <= load_addr;

      if (emitting) begin
        wr_en   <= 1'b1;
        wr_addr <= ptr;
        wr_data <= emitByte;
        ptr     <= ptr + 1'b1;
        if (&ptr) wrapped <= 1'b1;
      end

      if (pop) begin
        holdIr     <= {headEntry.irHi, ~headEntry.hasImm};
        holdImm    <= headEntry.imm;
        holdHasImm <= headEntry.hasImm;
      end

      case (state)
        IDLE: begin
          if (pop) state <= OPCODE;
        end
        OPCODE: begin
          if (holdHasImm)  state <= IMM;
          else if (!pop)   state <= IDLE;
        end
        IMM: begin
          state <= pop ? OPCODE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
